// File: rtl/base_stream_tx_if.sv
// Valid/ready base stream carrying one nucleotide per beat plus its position.
interface base_stream_tx_if #(
  parameter int BASE_W = 2,
  parameter int LEN_W  = 5
);
  logic              out_valid;
  logic [BASE_W-1:0] out_base;
  logic              out_last;
  logic              out_ready;
  logic [LEN_W-1:0]  idx;

  modport master (
    output out_valid,
    output out_base,
    output out_last,
    output idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_base,
    input  out_last,
    input  idx,
    output out_ready
  );
endinterface

// File: rtl/base_stream_tx.sv
// Sends a packed base sequence one base per beat, flags the final base and
// pulses done once the sequence is exhausted. All outputs come from registers.
module base_stream_tx #(
  parameter int BASE_W  = 2,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic [BASE_W*MAX_LEN-1:0] seq,
  output logic                      busy,
  output logic                      done,
  base_stream_tx_if.master          bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [BASE_W*MAX_LEN-1:0] shreg_reg, shreg_next;
  logic [LEN_W-1:0]          cnt_reg, cnt_next;
  logic [LEN_W-1:0]          idx_reg, idx_next;
  logic                      valid_reg, valid_next;
  logic                      last_reg, last_next;
  logic                      busy_reg, busy_next;
  logic                      done_reg, done_next;
  logic                      hold_reg, hold_next;

  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W:0]   idx_plus2;
  logic             handshake;

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign idx_plus2   = {1'b0, idx_reg} + (LEN_W+1)'(2);
  assign handshake   = valid_reg & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      hold_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    hold_next  = hold_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          shreg_next = seq;
          cnt_next   = len_clamped;
          idx_next   = '0;
          busy_next  = 1'b1;
          if (len_clamped != '0) begin
            state_next = SEND;
            valid_next = 1'b1;
            last_next  = (len_clamped == LEN_W'(1));
          end else begin
            // Empty sequence: spend one quiet busy cycle, then pulse done.
            state_next = DONE;
            hold_next  = 1'b1;
          end
        end
      end

      SEND: begin
        if (handshake) begin
          shreg_next = shreg_reg >> BASE_W;
          if (last_reg) begin
            state_next = DONE;
            valid_next = 1'b0;
            last_next  = 1'b0;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next  = idx_reg + LEN_W'(1);
            last_next = (idx_plus2 == {1'b0, cnt_reg});
          end
        end
      end

      DONE: begin
        if (hold_reg) begin
          hold_next = 1'b0;
          done_next = 1'b1;
        end else begin
          state_next = IDLE;
          done_next  = 1'b0;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        hold_next  = 1'b0;
      end
    endcase
  end

  assign bus.out_valid = valid_reg;
  assign bus.out_base  = shreg_reg[BASE_W-1:0];
  assign bus.out_last  = last_reg;
  assign bus.idx       = idx_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule
